// File: rtl/neureka_tcdm_responder_if.sv
// ---------------------------------------------------------------------------
// neureka_tcdm_responder_if
// HCI-core style TCDM bus between one wide initiator and one target.
//   Request : req, gnt, add, wen (1 = read), be, data, id, user
//   Response: r_valid, r_ready, r_data, r_id, r_user, r_opc (echoed wen)
// The initiator side uses modport master and the memory side uses modport slave.
// ---------------------------------------------------------------------------
interface neureka_tcdm_responder_if #(
    parameter int unsigned DW = 256,
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 8,
    parameter int unsigned UW = 1
);
    logic              req;
    logic              gnt;
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW/8-1:0]   be;
    logic [DW-1:0]     data;
    logic [IW-1:0]     id;
    logic [UW-1:0]     user;

    logic              r_valid;
    logic              r_ready;
    logic [DW-1:0]     r_data;
    logic [IW-1:0]     r_id;
    logic [UW-1:0]     r_user;
    logic              r_opc;

    modport master (
        output req, add, wen, be, data, id, user, r_ready,
        input  gnt, r_valid, r_data, r_id, r_user, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, id, user, r_ready,
        output gnt, r_valid, r_data, r_id, r_user, r_opc
    );
endinterface

// File: rtl/neureka_tcdm_responder.sv
// ---------------------------------------------------------------------------
// neureka_tcdm_responder
// Memory-side TCDM target: a byte-enabled word array with a fixed read
// latency, an in-order response buffer that absorbs r_ready backpressure,
// and a credit counter that withholds gnt so no response is ever dropped.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   clear_i          synchronous flush of pipeline/buffer/credits (memory kept)
//   stall_i          forces gnt low when STALL_EN != 0
//   tcdm             request/response bus (slave modport)
//   outstanding_o    granted-but-not-popped request count
// ---------------------------------------------------------------------------
module neureka_tcdm_responder #(
    parameter int unsigned DW             = 256,
    parameter int unsigned AW             = 32,
    parameter int unsigned IW             = 8,
    parameter int unsigned UW             = 1,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned LATENCY        = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 2,
    parameter int unsigned STALL_EN       = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic                                  stall_i,
    neureka_tcdm_responder_if.slave               tcdm,
    output logic [$clog2(RSP_FIFO_DEPTH+1)-1:0]   outstanding_o
);
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OFF  = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned PW   = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic          opc;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
    } meta_t;

    typedef struct packed {
        meta_t         meta;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0]      mem [DEPTH];
    logic [DW-1:0]      data_pipe_reg [LATENCY];
    meta_t              meta_pipe_reg [LATENCY];
    logic [LATENCY-1:0] valid_pipe_reg;
    rsp_t               fifo_reg [RSP_FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      fifo_cnt_reg, outstanding_reg;

    logic               flush, stall_eff, gnt, pop, r_valid;
    logic               fifo_empty, fifo_push, fifo_pop;
    logic [AW-1:0]      word_addr;
    logic [IDXW-1:0]    word_idx;
    logic [NB-1:0]      byte_we;
    rsp_t               tail_rsp, head_rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign flush     = rst_i | clear_i;
    assign stall_eff = (STALL_EN != 0) ? stall_i : 1'b0;
    assign word_addr = tcdm.add >> OFF;
    assign word_idx  = IDXW'(word_addr % AW'(DEPTH));

    // Credit check allows a grant into the slot freed by a same-cycle pop.
    assign pop = r_valid & tcdm.r_ready;
    assign gnt = tcdm.req & ~stall_eff & ~flush
               & ((outstanding_reg < CW'(RSP_FIFO_DEPTH)) | pop);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte_we
            assign byte_we[gi] = gnt & ~tcdm.wen & tcdm.be[gi];
        end
    endgenerate

    // Pipeline tail: write responses carry zero data.
    assign tail_rsp.meta = meta_pipe_reg[LATENCY-1];
    assign tail_rsp.data = meta_pipe_reg[LATENCY-1].opc ? data_pipe_reg[LATENCY-1] : '0;

    // The tail is presented directly when the buffer is empty so LATENCY is
    // not stretched; if it is not popped it moves into the buffer and stays
    // at the head, so the outputs remain stable.
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign head_rsp   = fifo_empty ? tail_rsp : fifo_reg[rd_ptr_reg];
    assign r_valid    = ~fifo_empty | valid_pipe_reg[LATENCY-1];
    assign fifo_pop   = pop & ~fifo_empty;
    assign fifo_push  = valid_pipe_reg[LATENCY-1] & ~(pop & fifo_empty);

    // Data path: no reset, so memory survives rst_i/clear_i.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (byte_we[b]) begin
                mem[word_idx][b*8 +: 8] <= tcdm.data[b*8 +: 8];
            end
        end
        data_pipe_reg[0] <= mem[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            data_pipe_reg[i] <= data_pipe_reg[i-1];
        end
        if (fifo_push) begin
            fifo_reg[wr_ptr_reg] <= tail_rsp;
        end
    end

    // Control path: valids, sideband, pointers and credits.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            valid_pipe_reg  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                meta_pipe_reg[i] <= '0;
            end
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fifo_cnt_reg    <= '0;
            outstanding_reg <= '0;
        end else begin
            valid_pipe_reg[0]     <= gnt;
            meta_pipe_reg[0].opc  <= tcdm.wen;
            meta_pipe_reg[0].user <= tcdm.user;
            meta_pipe_reg[0].id   <= tcdm.id;
            for (int i = 1; i < LATENCY; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                meta_pipe_reg[i]  <= meta_pipe_reg[i-1];
            end
            if (fifo_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (fifo_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            fifo_cnt_reg    <= fifo_cnt_reg + CW'(fifo_push) - CW'(fifo_pop);
            outstanding_reg <= outstanding_reg + CW'(gnt) - CW'(pop);
        end
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid;
    assign tcdm.r_data  = r_valid ? head_rsp.data      : '0;
    assign tcdm.r_id    = r_valid ? head_rsp.meta.id   : '0;
    assign tcdm.r_user  = r_valid ? head_rsp.meta.user : '0;
    assign tcdm.r_opc   = r_valid ? head_rsp.meta.opc  : 1'b0;
    assign outstanding_o = outstanding_reg;
endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// ---------------------------------------------------------------------------
// tb_neureka_tcdm_responder
// Two responders (LATENCY=1/credits=2 and LATENCY=3/credits=3) share one
// stimulus path selected by 'sel'. A transaction-level model (memory array
// plus a queue of expected responses with their ready cycle) predicts gnt,
// r_valid, outstanding and every response field each cycle.
// ---------------------------------------------------------------------------
module tb_neureka_tcdm_responder;
    localparam int DW = 64, AW = 32, IW = 8, UW = 2, DEPTH = 16, NB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, stall, sel, req, wen, r_ready;
    logic [AW-1:0] add;
    logic [NB-1:0] be;
    logic [DW-1:0] wdata;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic [1:0]    out_a, out_b;

    neureka_tcdm_responder_if #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) bus_a ();
    neureka_tcdm_responder_if #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) bus_b ();

    assign bus_a.req = req & ~sel;      assign bus_b.req = req & sel;
    assign bus_a.r_ready = r_ready & ~sel; assign bus_b.r_ready = r_ready & sel;
    assign bus_a.add = add;   assign bus_b.add = add;
    assign bus_a.wen = wen;   assign bus_b.wen = wen;
    assign bus_a.be = be;     assign bus_b.be = be;
    assign bus_a.data = wdata; assign bus_b.data = wdata;
    assign bus_a.id = id;     assign bus_b.id = id;
    assign bus_a.user = user; assign bus_b.user = user;

    neureka_tcdm_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .DEPTH(DEPTH),
        .LATENCY(1), .RSP_FIFO_DEPTH(2), .STALL_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
        .tcdm(bus_a), .outstanding_o(out_a));

    neureka_tcdm_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .DEPTH(DEPTH),
        .LATENCY(3), .RSP_FIFO_DEPTH(3), .STALL_EN(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
        .tcdm(bus_b), .outstanding_o(out_b));

    logic          gnt_o, r_valid_o, r_opc_o;
    logic [DW-1:0] r_data_o;
    logic [IW-1:0] r_id_o;
    logic [UW-1:0] r_user_o;
    logic [1:0]    outst;
    assign gnt_o     = sel ? bus_b.gnt     : bus_a.gnt;
    assign r_valid_o = sel ? bus_b.r_valid : bus_a.r_valid;
    assign r_data_o  = sel ? bus_b.r_data  : bus_a.r_data;
    assign r_id_o    = sel ? bus_b.r_id    : bus_a.r_id;
    assign r_user_o  = sel ? bus_b.r_user  : bus_a.r_user;
    assign r_opc_o   = sel ? bus_b.r_opc   : bus_a.r_opc;
    assign outst     = sel ? out_b         : out_a;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic          opc;
        int            ready;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mdl_mem [2][DEPTH];
    logic [DW-1:0] last_rsp_data;
    int            cyc, checks, failures, dut_gnt_cnt, waited;
    bit            exp_gnt, after_flush;

    function automatic int lat();
        return sel ? 3 : 1;
    endfunction

    function automatic int credits();
        return sel ? 3 : 2;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d, sel %0d)", tag, obs, exp, cyc, sel);
        end
    endtask

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic cycle();
        bit   exp_valid, exp_pop;
        int   idx;
        exp_t e;
        #1;
        exp_valid = (q.size() > 0) && (q[0].ready <= cyc);
        exp_pop   = exp_valid && r_ready;
        exp_gnt   = req && !rst && !clear && !stall && ((q.size() < credits()) || exp_pop);
        if (gnt_o === 1'b1) dut_gnt_cnt++;
        chk("gnt", DW'(gnt_o), DW'(exp_gnt));
        chk("r_valid", DW'(r_valid_o), DW'(exp_valid));
        chk("outstanding", DW'(outst), DW'(q.size()));
        if (exp_valid) begin
            chk("r_data", r_data_o, q[0].data);
            chk("r_id", DW'(r_id_o), DW'(q[0].id));
            chk("r_user", DW'(r_user_o), DW'(q[0].user));
            chk("r_opc", DW'(r_opc_o), DW'(q[0].opc));
        end
        if (after_flush) begin
            chk("flush_r_data", r_data_o, '0);
            chk("flush_r_id", DW'(r_id_o), '0);
            chk("flush_r_user", DW'(r_user_o), '0);
            chk("flush_r_opc", DW'(r_opc_o), '0);
        end
        if (exp_pop) last_rsp_data = r_data_o;
        after_flush = rst || clear;
        if (rst || clear) begin
            q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_gnt) begin
                idx    = int'((add >> 3) % DEPTH);
                e.id   = id;
                e.user = user;
                e.opc  = wen;
                e.ready = cyc + lat();
                if (wen) begin
                    e.data = mdl_mem[int'(sel)][idx];
                end else begin
                    e.data = '0;
                    for (int b = 0; b < NB; b++)
                        if (be[b]) mdl_mem[int'(sel)][idx][b*8 +: 8] = wdata[b*8 +: 8];
                end
                q.push_back(e);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic w, input int a, input logic [NB-1:0] b,
                             input logic [DW-1:0] d, input int i, input int u);
        req = 1'b1; wen = w; add = AW'(a); be = b; wdata = d; id = IW'(i); user = UW'(u);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!exp_gnt && n < 50);
        chk("gnt_wait_bound", DW'(exp_gnt), DW'(1));
        req = 1'b0;
    endtask

    task automatic issue(input logic w, input int a, input logic [NB-1:0] b,
                         input logic [DW-1:0] d, input int i, input int u);
        int n;
        drive_req(w, a, b, d, i, u);
        wait_gnt(n);
    endtask

    task automatic drain();
        int n = 0;
        req = 1'b0; r_ready = 1'b1; stall = 1'b0; clear = 1'b0;
        while (q.size() > 0 && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_bound", DW'(q.size()), '0);
        cycle();
    endtask

    task automatic rand_phase(input int n);
        bit pending = 0;
        for (int k = 0; k < n; k++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                drive_req($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                          NB'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)));
                pending = 1;
            end
            r_ready = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 7) == 0);
            clear   = ($urandom_range(0, 63) == 0);
            cycle();
            if (exp_gnt) begin
                pending = 0;
                req = 1'b0;
            end
        end
        drain();
    endtask

    localparam logic [DW-1:0] PATTERN = {8{8'hA5}};

    initial begin
        rst = 1'b1; clear = 1'b0; stall = 1'b0; sel = 1'b0; req = 1'b0; wen = 1'b1;
        add = '0; be = '0; wdata = '0; id = '0; user = '0; r_ready = 1'b1;
        cyc = 0; checks = 0; failures = 0; after_flush = 0; dut_gnt_cnt = 0;
        last_rsp_data = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Preload every word of both memories; word 5 starts at zero.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < DEPTH; w++)
                issue(1'b0, w * 8, '1, (w == 5) ? '0 : {$urandom, $urandom}, w, 0);
            drain();
        end

        // ---- LATENCY=1, credits=2 ----
        sel = 1'b0;
        issue(1'b0, 3 * 8, '1, PATTERN, 7, 0);
        issue(1'b1, 3 * 8, '0, '0, 9, 1);
        drain();
        chk("raw_data", last_rsp_data, PATTERN);

        issue(1'b0, 5 * 8 + 3, 8'h01, '1, 1, 0);   // unaligned low bits ignored
        issue(1'b1, 5 * 8, '0, '0, 2, 0);
        drain();
        chk("byte_enable", last_rsp_data, 64'h00000000_000000FF);

        // Backpressure: only two of four reads may be granted.
        r_ready = 1'b0;
        issue(1'b1, 3 * 8, '0, '0, 20, 0);
        issue(1'b1, 5 * 8, '0, '0, 21, 0);
        drive_req(1'b1, 3 * 8, '0, '0, 22, 0);
        dut_gnt_cnt = 0;
        repeat (3) cycle();
        chk("bp_no_gnt", DW'(dut_gnt_cnt), '0);
        chk("bp_outstanding", DW'(outst), DW'(2));
        r_ready = 1'b1;
        wait_gnt(waited);
        issue(1'b1, 5 * 8, '0, '0, 23, 0);
        drain();

        // Clear with two buffered responses.
        r_ready = 1'b0;
        issue(1'b1, 3 * 8, '0, '0, 30, 0);
        issue(1'b1, 5 * 8, '0, '0, 31, 0);
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        chk("clear_outstanding", DW'(outst), '0);
        issue(1'b1, 3 * 8, '0, '0, 32, 0);
        drain();
        chk("clear_mem_kept", last_rsp_data, PATTERN);

        // Stall for five cycles.
        stall = 1'b1;
        drive_req(1'b1, 5 * 8, '0, '0, 40, 0);
        dut_gnt_cnt = 0;
        repeat (5) cycle();
        chk("stall_no_gnt", DW'(dut_gnt_cnt), '0);
        stall = 1'b0;
        wait_gnt(waited);
        drain();

        // Reset with two reads in flight.
        r_ready = 1'b0;
        issue(1'b1, 3 * 8, '0, '0, 50, 0);
        issue(1'b1, 5 * 8, '0, '0, 51, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        r_ready = 1'b1;
        repeat (4) cycle();
        issue(1'b1, 3 * 8, '0, '0, 52, 0);
        drain();
        chk("reset_mem_kept", last_rsp_data, PATTERN);

        rand_phase(300);

        // ---- LATENCY=3, credits=3 ----
        sel = 1'b1;
        r_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_req(1'b1, i * 8, '0, '0, i, 0);
            wait_gnt(waited);
            chk("stream_gnt_every_cycle", DW'(waited), DW'(1));
            req = 1'b0;
        end
        drain();

        rand_phase(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
